// File: rtl/control_muestreo_ipd_if.sv
// control_muestreo_ipd_if
// Bundles the sample-scheduler signals between the I_PD datapath side and
// the scheduler itself.
//   slave  modport: used by control_muestreo_ipd. It receives run, adc_done,
//                   adc_data and ref_in, and drives every other signal.
//   master modport: used by the environment around the scheduler (ADC,
//                   supervisor, PWM). Directions are the reverse of slave.
// Parameters: N (signed datapath word width), ADC (raw sample width).
interface control_muestreo_ipd_if #(
    parameter int N   = 18,
    parameter int ADC = 12
);
    logic                  run;
    logic                  adc_start;
    logic                  adc_done;
    logic [ADC-1:0]        adc_data;
    logic [ADC-1:0]        ref_in;
    logic signed [N-1:0]   y;
    logic signed [N-1:0]   referencia;
    logic                  ipd_enable;
    logic                  pwm_load;
    logic                  busy;
    logic                  overrun;
    logic                  timeout_err;
    logic [15:0]           n_muestras;

    modport slave (
        input  run, adc_done, adc_data, ref_in,
        output adc_start, y, referencia, ipd_enable, pwm_load,
               busy, overrun, timeout_err, n_muestras
    );

    modport master (
        output run, adc_done, adc_data, ref_in,
        input  adc_start, y, referencia, ipd_enable, pwm_load,
               busy, overrun, timeout_err, n_muestras
    );
endinterface

// File: rtl/control_muestreo_ipd.sv
// control_muestreo_ipd
// Sample-period scheduler for the I_PD conditioning datapath. It divides clk
// down to the control sample rate and starts one ADC conversion per period.
// It captures the ADC result and the reference with the mid-scale offset
// removed, then pulses ipd_enable. LATENCIA+1 cycles later it strobes
// pwm_load, so the controller advances exactly once per sample.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous, active-low
//   bus    control_muestreo_ipd_if.slave:
//          run, adc_done, adc_data, ref_in                   (inputs)
//          adc_start, y, referencia, ipd_enable, pwm_load,
//          busy, overrun, timeout_err, n_muestras            (outputs)
// Build option: define ADC_TIMEOUT_EN to abandon a sample when adc_done does
// not arrive within TIMEOUT cycles. Without it, timeout_err is tied to 0.
module control_muestreo_ipd #(
    parameter int N        = 18,
    parameter int ADC      = 12,
    parameter int PERIODO  = 50000,
    parameter int TIMEOUT  = 1000,
    parameter int LATENCIA = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    control_muestreo_ipd_if.slave bus
);
    localparam int CW = $clog2(PERIODO);
    localparam int LW = (LATENCIA > 0) ? $clog2(LATENCIA + 1) : 1;
    localparam logic signed [N-1:0] MEDIA_ESCALA = N'(2048);

    typedef enum logic [2:0] {IDLE, START, WAIT_ADC, COMPUTE, SETTLE, UPDATE} state_t;

    state_t              state;
    logic [CW-1:0]       cuenta;
    logic [LW-1:0]       lat;
    logic                tick;
    logic                adc_start_r;
    logic                ipd_enable_r;
    logic                pwm_load_r;
    logic                overrun_r;
    logic signed [N-1:0] y_r;
    logic signed [N-1:0] ref_r;
    logic [15:0]         n_r;

    // Offset-binary to two's complement. The zero-extended sample is always
    // in range, so the result needs no saturation.
    function automatic logic signed [N-1:0] quita_offset(input logic [ADC-1:0] raw);
        logic signed [N-1:0] ext;
        ext = {{(N-ADC){1'b0}}, raw};
        return ext - MEDIA_ESCALA;
    endfunction

`ifdef ADC_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] espera;
    logic          timeout_r;
    assign bus.timeout_err = timeout_r;
`else
    // TIMEOUT only sizes the timeout counter, which this build does not have.
    logic unused_timeout;
    assign unused_timeout  = ^TIMEOUT;
    assign bus.timeout_err = 1'b0;
`endif

    // Gating tick with run means that a period ending exactly as run drops
    // does not start a new sample.
    assign tick = bus.run && (cuenta == CW'(PERIODO - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cuenta <= '0;
        end else if (!bus.run || tick) begin
            cuenta <= '0;
        end else begin
            cuenta <= cuenta + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            adc_start_r  <= 1'b0;
            ipd_enable_r <= 1'b0;
            pwm_load_r   <= 1'b0;
            overrun_r    <= 1'b0;
            y_r          <= '0;
            ref_r        <= '0;
            lat          <= '0;
            n_r          <= '0;
`ifdef ADC_TIMEOUT_EN
            espera       <= '0;
            timeout_r    <= 1'b0;
`endif
        end else begin
            adc_start_r  <= 1'b0;
            ipd_enable_r <= 1'b0;
            pwm_load_r   <= 1'b0;

            // A tick that finds a sample in flight is dropped, not queued.
            if (tick && state != IDLE) begin
                overrun_r <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (tick) begin
                        state       <= START;
                        adc_start_r <= 1'b1;
                    end
                end
                START: begin
                    state <= WAIT_ADC;
`ifdef ADC_TIMEOUT_EN
                    espera <= '0;
`endif
                end
                WAIT_ADC: begin
                    if (bus.adc_done) begin
                        y_r          <= quita_offset(bus.adc_data);
                        ref_r        <= quita_offset(bus.ref_in);
                        ipd_enable_r <= 1'b1;
                        state        <= COMPUTE;
                    end
`ifdef ADC_TIMEOUT_EN
                    else if (espera == TW'(TIMEOUT - 1)) begin
                        timeout_r <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        espera <= espera + TW'(1);
                    end
`endif
                end
                COMPUTE: begin
                    lat <= LW'(LATENCIA);
                    if (LATENCIA == 0) begin
                        pwm_load_r <= 1'b1;
                        state      <= UPDATE;
                    end else begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    // The last SETTLE cycle is the one where lat is 1, which
                    // gives LATENCIA cycles here and places pwm_load
                    // LATENCIA+1 cycles after ipd_enable.
                    lat <= lat - LW'(1);
                    if (lat == LW'(1)) begin
                        pwm_load_r <= 1'b1;
                        state      <= UPDATE;
                    end
                end
                UPDATE: begin
                    n_r   <= n_r + 16'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.adc_start  = adc_start_r;
    assign bus.ipd_enable = ipd_enable_r;
    assign bus.pwm_load   = pwm_load_r;
    assign bus.busy       = (state != IDLE);
    assign bus.overrun    = overrun_r;
    assign bus.y          = y_r;
    assign bus.referencia = ref_r;
    assign bus.n_muestras = n_r;
endmodule
